// File: rtl/core_pkg.sv
// core_pkg: shared core types and constants, including the hazard FSM state
package core_pkg;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int HZ_MC_TIMEOUT_DEF = 64;
  typedef enum logic {HZ_RUN, HZ_MC_WAIT} hz_state_e;
endpackage

// File: rtl/hz_sat_counter.sv
// hz_sat_counter: event counter that sticks at all-ones instead of wrapping
module hz_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);
  always_ff @(posedge clk_i)
    if (rst_i) cnt_o <= '0;
    else if (inc_i && !(&cnt_o)) cnt_o <= cnt_o + WIDTH'(1);
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: load-use/redirect/multi-cycle stall+flush control; HAZARD_PERF_CNT_EN adds perf counters
module hazard_ctrl_unit
  import core_pkg::*;
#(
  parameter int MC_TIMEOUT = HZ_MC_TIMEOUT_DEF,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      MemRead_EX_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_EX_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_ID_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_ID_i,
  input  logic                      rs1_used_ID_i,
  input  logic                      rs2_used_ID_i,
  input  logic                      redirect_EX_i,
  input  logic                      mc_start_EX_i,
  input  logic                      mc_done_i,
  output logic                      stall_IF_o,
  output logic                      stall_ID_o,
  output logic                      stall_EX_o,
  output logic                      flush_ID_o,
  output logic                      flush_EX_o,
  output logic                      flush_MEM_o,
  output logic                      mc_busy_o,
  output logic                      mc_timeout_o,
  output logic [CNT_WIDTH-1:0]      perf_lu_cnt_o,
  output logic [CNT_WIDTH-1:0]      perf_rd_cnt_o,
  output logic [CNT_WIDTH-1:0]      perf_mc_cnt_o
);
  localparam int TW = $clog2(MC_TIMEOUT + 1);
  hz_state_e state;
  logic [TW-1:0] wait_cnt;
  logic load_use, mc_enter, in_run, release_mc, rd_flush, lu_stall, mc_stall;
  always_comb begin
    load_use = MemRead_EX_i && rd_addr_EX_i != '0 &&
               ((rs1_used_ID_i && rs1_addr_ID_i == rd_addr_EX_i) ||
                (rs2_used_ID_i && rs2_addr_ID_i == rd_addr_EX_i));
    mc_enter = mc_start_EX_i && !mc_done_i;
    in_run = state == HZ_RUN;
    release_mc = mc_done_i || wait_cnt == TW'(MC_TIMEOUT);
    rd_flush = in_run && redirect_EX_i;
    mc_stall = in_run ? mc_enter && !redirect_EX_i : !release_mc;
    lu_stall = in_run && !redirect_EX_i && !mc_enter && load_use;
    stall_IF_o = mc_stall || lu_stall;
    stall_ID_o = mc_stall || lu_stall;
    stall_EX_o = mc_stall;
    flush_ID_o = rd_flush;
    flush_EX_o = rd_flush || lu_stall;
    flush_MEM_o = mc_stall;
    mc_busy_o = !in_run && !release_mc;
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= HZ_RUN;
      wait_cnt <= '0;
      mc_timeout_o <= 1'b0;
    end else if (in_run) begin
      if (mc_stall) begin
        state <= HZ_MC_WAIT;
        wait_cnt <= TW'(1);
      end
    end else if (release_mc) begin
      state <= HZ_RUN;
      if (!mc_done_i) mc_timeout_o <= 1'b1;
    end else if (!(&wait_cnt)) begin
      wait_cnt <= wait_cnt + TW'(1);
    end
  assert property (@(posedge clk_i) disable iff (rst_i) !(redirect_EX_i && mc_start_EX_i));
`ifdef HAZARD_PERF_CNT_EN
  hz_sat_counter #(.WIDTH(CNT_WIDTH)) u_lu (.clk_i(clk_i), .rst_i(rst_i), .inc_i(lu_stall), .cnt_o(perf_lu_cnt_o));
  hz_sat_counter #(.WIDTH(CNT_WIDTH)) u_rd (.clk_i(clk_i), .rst_i(rst_i), .inc_i(rd_flush), .cnt_o(perf_rd_cnt_o));
  hz_sat_counter #(.WIDTH(CNT_WIDTH)) u_mc (.clk_i(clk_i), .rst_i(rst_i), .inc_i(mc_stall), .cnt_o(perf_mc_cnt_o));
`else
  assign perf_lu_cnt_o = '0;
  assign perf_rd_cnt_o = '0;
  assign perf_mc_cnt_o = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: vector table, corner sequences and random run against a reference model
module tb_hazard_ctrl_unit;
  import core_pkg::*;
  localparam int TO = 8;
  localparam int CW = 32;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [6:0] IDLE = 7'b0000000;
  localparam logic [6:0] LU   = 7'b1100100;
  localparam logic [6:0] RD   = 7'b0001100;
  localparam logic [6:0] MCE  = 7'b1110010;
  localparam logic [6:0] MCB  = 7'b1110011;
  typedef struct packed {
    logic mr;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic u1;
    logic u2;
    logic redir;
    logic mcs;
    logic mcd;
  } in_t;
  typedef struct packed {
    in_t i;
    logic [6:0] e;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic mr, u1, u2, redir, mcs, mcd;
  logic [REG_ADDR_WIDTH-1:0] rd, rs1, rs2;
  logic s_if, s_id, s_ex, f_id, f_ex, f_mem, busy, tmo;
  logic [CW-1:0] p_lu, p_rd, p_mc;
  logic [6:0] ctl;
  int n_chk = 0, n_fail = 0;
  bit m_wait, m_to;
  int m_elapsed, m_lu, m_rd, m_mc;
  vec_t vecs[10];
  always #5 clk = ~clk;
  assign ctl = {s_if, s_id, s_ex, f_id, f_ex, f_mem, busy};
  hazard_ctrl_unit #(.MC_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst), .MemRead_EX_i(mr), .rd_addr_EX_i(rd),
    .rs1_addr_ID_i(rs1), .rs2_addr_ID_i(rs2), .rs1_used_ID_i(u1), .rs2_used_ID_i(u2),
    .redirect_EX_i(redir), .mc_start_EX_i(mcs), .mc_done_i(mcd),
    .stall_IF_o(s_if), .stall_ID_o(s_id), .stall_EX_o(s_ex),
    .flush_ID_o(f_id), .flush_EX_o(f_ex), .flush_MEM_o(f_mem),
    .mc_busy_o(busy), .mc_timeout_o(tmo),
    .perf_lu_cnt_o(p_lu), .perf_rd_cnt_o(p_rd), .perf_mc_cnt_o(p_mc)
  );
  function automatic in_t mk(logic a_mr, int a_rd, int a_rs1, int a_rs2, logic a_u1, logic a_u2,
                             logic a_redir, logic a_mcs, logic a_mcd);
    in_t r;
    r.mr = a_mr;
    r.rd = REG_ADDR_WIDTH'(a_rd);
    r.rs1 = REG_ADDR_WIDTH'(a_rs1);
    r.rs2 = REG_ADDR_WIDTH'(a_rs2);
    r.u1 = a_u1;
    r.u2 = a_u2;
    r.redir = a_redir;
    r.mcs = a_mcs;
    r.mcd = a_mcd;
    return r;
  endfunction
  function automatic logic [6:0] model_ctl(in_t i);
    bit lu;
    lu = i.mr && i.rd != 0 && ((i.u1 && i.rs1 == i.rd) || (i.u2 && i.rs2 == i.rd));
    if (m_wait) return (i.mcd || m_elapsed == TO) ? IDLE : MCB;
    if (i.redir) return RD;
    if (i.mcs && !i.mcd) return MCE;
    if (lu) return LU;
    return IDLE;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input in_t i);
    mr = i.mr; rd = i.rd; rs1 = i.rs1; rs2 = i.rs2;
    u1 = i.u1; u2 = i.u2; redir = i.redir; mcs = i.mcs; mcd = i.mcd;
  endtask
  task automatic model_reset();
    m_wait = 0; m_to = 0; m_elapsed = 0; m_lu = 0; m_rd = 0; m_mc = 0;
  endtask
  task automatic cyc(input in_t i, input logic [6:0] e, input string nm);
    drive(i);
    #1;
    chk(nm, 64'(ctl), 64'(e));
    chk({nm, "_tmo"}, 64'(tmo), 64'(m_to));
    if (e == LU) m_lu++;
    if (e == RD) m_rd++;
    if (e[4]) m_mc++;
    if (m_wait) begin
      if (i.mcd || m_elapsed == TO) begin
        if (!i.mcd) m_to = 1;
        m_wait = 0;
      end else m_elapsed++;
    end else if (!i.redir && i.mcs && !i.mcd) begin
      m_wait = 1;
      m_elapsed = 1;
    end
    @(negedge clk);
  endtask
  task automatic chk_perf(input string nm);
    chk({nm, "_lu"}, 64'(p_lu), PERF ? 64'(m_lu) : 64'd0);
    chk({nm, "_rd"}, 64'(p_rd), PERF ? 64'(m_rd) : 64'd0);
    chk({nm, "_mc"}, 64'(p_mc), PERF ? 64'(m_mc) : 64'd0);
  endtask
  task automatic do_reset();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask
  initial begin
    in_t idle, ri;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[0] = '{mk(1, 5, 5, 0, 1, 0, 0, 0, 0), LU};
    vecs[1] = '{mk(1, 0, 0, 0, 1, 1, 0, 0, 0), IDLE};
    vecs[2] = '{mk(1, 7, 0, 7, 0, 0, 0, 0, 0), IDLE};
    vecs[3] = '{mk(1, 7, 0, 7, 0, 1, 0, 0, 0), LU};
    vecs[4] = '{mk(0, 5, 5, 5, 1, 1, 0, 0, 0), IDLE};
    vecs[5] = '{mk(1, 3, 4, 2, 1, 1, 0, 0, 0), IDLE};
    vecs[6] = '{mk(1, 9, 9, 0, 1, 0, 1, 0, 0), RD};
    vecs[7] = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 1), IDLE};
    vecs[8] = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 0), RD};
    vecs[9] = '{mk(1, 6, 6, 6, 1, 1, 0, 1, 1), LU};
    drive(idle);
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("in_reset_ctl", 64'(ctl), 64'(IDLE));
    rst = 0;
    model_reset();
    @(negedge clk);
    #1;
    chk("post_reset_ctl", 64'(ctl), 64'(IDLE));
    chk("post_reset_tmo", 64'(tmo), 64'd0);
    chk_perf("post_reset_perf");
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      cyc(vecs[k].i, vecs[k].e, $sformatf("vec%0d", k));
      cyc(idle, IDLE, $sformatf("vec%0d_after", k));
    end
    chk_perf("table_perf");
    do_reset();
    cyc(mk(1, 5, 5, 0, 1, 0, 1, 0, 0), RD, "rd_vs_lu");
    chk("rd_vs_lu_rdcnt", 64'(p_rd), PERF ? 64'd1 : 64'd0);
    chk("rd_vs_lu_lucnt", 64'(p_lu), 64'd0);
    do_reset();
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), MCE, "div_enter");
    cyc(idle, MCB, "div_w1");
    cyc(mk(1, 5, 5, 0, 1, 0, 0, 0, 0), MCB, "div_w2_lu_ignored");
    cyc(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), MCB, "div_w3_rd_ignored");
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), IDLE, "div_done");
    cyc(idle, IDLE, "div_after");
    chk("div_perf_mc", 64'(p_mc), PERF ? 64'd4 : 64'd0);
    chk("div_perf_rd", 64'(p_rd), 64'd0);
    do_reset();
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), MCE, "to_enter");
    for (int k = 1; k < TO; k++) cyc(idle, MCB, $sformatf("to_w%0d", k));
    cyc(idle, IDLE, "to_release");
    #1;
    chk("to_flag_set", 64'(tmo), 64'd1);
    for (int k = 0; k < 3; k++) cyc(idle, IDLE, $sformatf("to_sticky%0d", k));
    cyc(mk(1, 5, 5, 0, 1, 0, 0, 0, 0), LU, "to_then_lu");
    chk("to_perf_mc", 64'(p_mc), PERF ? 64'(TO) : 64'd0);
    do_reset();
    #1;
    chk("to_cleared", 64'(tmo), 64'd0);
    @(negedge clk);
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), MCE, "rmw_enter");
    cyc(idle, MCB, "rmw_w1");
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
    #1;
    chk("rmw_ctl", 64'(ctl), 64'(IDLE));
    chk("rmw_tmo", 64'(tmo), 64'd0);
    chk_perf("rmw_perf");
    @(negedge clk);
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      ri = mk($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
      if (ri.redir && ri.mcs) ri.mcs = 0;
      cyc(ri, model_ctl(ri), "rand");
      if (n % 500 == 499) chk_perf("rand_perf");
    end
    chk_perf("final_perf");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
